// File: rtl/csa_accum_sched.sv
// Multi-beat carry-save accumulator: a shared bank of W 7:3 counters folds four
// rows per beat into three carry-save rows, then resolves them with one add.
module csa_accum_sched #(
  parameter int W    = 16,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4*W-1:0]  in_rows,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_sum,
  output logic [CNTW-1:0] out_beats,
  output logic            busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCUM   = 3'd1,
    ST_FLUSH   = 3'd2,
    ST_RESOLVE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t          state_r, state_nx_s;
  logic [W-1:0]    a0_r, a1_r, a2_r;
  logic [W-1:0]    a0_nx_s, a1_nx_s, a2_nx_s;
  logic [CNTW-1:0] bc_r, bc_inc_s;
  logic [4*W-1:0]  rows_s;
  logic [6:0]      cols_s [W];
  logic            xfer_s;

  // Compressor73: weighted population count of seven bits.
  function automatic logic [2:0] compress73(input logic [6:0] x);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 7; i++) begin
      cnt = cnt + {2'b00, x[i]};
    end
    return cnt;
  endfunction

  assign in_ready = (state_r == ST_IDLE) || (state_r == ST_ACCUM);
  assign busy     = (state_r != ST_IDLE);
  assign xfer_s   = in_valid && in_ready;
  assign rows_s   = (state_r == ST_FLUSH) ? {(4*W){1'b0}} : in_rows;
  assign bc_inc_s = (bc_r == {CNTW{1'b1}}) ? bc_r : bc_r + {{(CNTW-1){1'b0}}, 1'b1};

  // Column gathering and the 7:3 bank; c2 and c1 are realigned by weight.
  always_comb begin
    logic [2:0] cnt;
    cnt     = 3'd0;
    a0_nx_s = {W{1'b0}};
    a1_nx_s = {W{1'b0}};
    a2_nx_s = {W{1'b0}};
    for (int j = 0; j < W; j++) begin
      cols_s[j] = {a2_r[j], a1_r[j], a0_r[j],
                   rows_s[3*W+j], rows_s[2*W+j], rows_s[W+j], rows_s[j]};
    end
    for (int j = 0; j < W; j++) begin
      cnt        = compress73(cols_s[j]);
      a0_nx_s[j] = cnt[0];
    end
    for (int j = 1; j < W; j++) begin
      cnt        = compress73(cols_s[j-1]);
      a1_nx_s[j] = cnt[1];
    end
    for (int j = 2; j < W; j++) begin
      cnt        = compress73(cols_s[j-2]);
      a2_nx_s[j] = cnt[2];
    end
  end

  // Sequencer next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s) begin
          state_nx_s = in_last ? ST_FLUSH : ST_ACCUM;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (xfer_s && in_last) begin
          state_nx_s = ST_FLUSH;
        end else begin
          state_nx_s = ST_ACCUM;
        end
      end
      ST_FLUSH:   state_nx_s = ST_RESOLVE;
      ST_RESOLVE: state_nx_s = ST_DONE;
      ST_DONE: begin
        if (out_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default:    state_nx_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Carry-save rows, beat counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0_r      <= {W{1'b0}};
      a1_r      <= {W{1'b0}};
      a2_r      <= {W{1'b0}};
      bc_r      <= {CNTW{1'b0}};
      out_valid <= 1'b0;
      out_sum   <= {W{1'b0}};
      out_beats <= {CNTW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (xfer_s) begin
            a0_r <= a0_nx_s;
            a1_r <= a1_nx_s;
            a2_r <= a2_nx_s;
            bc_r <= {{(CNTW-1){1'b0}}, 1'b1};
          end
        end
        ST_ACCUM: begin
          if (xfer_s) begin
            a0_r <= a0_nx_s;
            a1_r <= a1_nx_s;
            a2_r <= a2_nx_s;
            bc_r <= bc_inc_s;
          end
        end
        // Rows are forced to zero here, so the final compress leaves A2 empty.
        ST_FLUSH: begin
          a0_r <= a0_nx_s;
          a1_r <= a1_nx_s;
          a2_r <= a2_nx_s;
        end
        ST_RESOLVE: begin
          out_sum   <= a0_r + a1_r;
          out_beats <= bc_r;
          out_valid <= 1'b1;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            a0_r      <= {W{1'b0}};
            a1_r      <= {W{1'b0}};
            a2_r      <= {W{1'b0}};
            bc_r      <= {CNTW{1'b0}};
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
